// File: rtl/shared_bus_pkg.sv
// Shared types and defaults for the tri-state bus arbiter.
package shared_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int HOLD_W       = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: search starts one past last_owner and wraps.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_owner,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] winner
);

    localparam int IW = $clog2(NREQ);

    int unsigned w_idx;
    logic        w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = 0;
        winner  = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            w_idx = 32'(last_owner) + off;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                winner  = IW'(w_idx);
            end
        end
        valid = w_found;
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Grants one requester at a time onto a shared tri-state net, with a hold limit
// and a mandatory one-cycle turnaround between owners.
module shared_bus_arbiter
    import shared_bus_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         drv_en,
    output logic [$clog2(NREQ)-1:0] owner_id,
    output logic                    bus_busy,
    output logic                    preempt
);

    localparam int IW = $clog2(NREQ);

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_last;
    logic [HOLD_W-1:0] r_hold;
    logic              r_preempt;

    logic              w_valid;
    logic [IW-1:0]     w_win;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req        (req),
        .last_owner (r_last),
        .valid      (w_valid),
        .winner     (w_win)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_last    <= IW'(NREQ - 1);
            r_hold    <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                IDLE, TURN: begin
                    if (w_valid) begin
                        r_state <= OWN;
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_hold  <= HOLD_W'(1);
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_owner <= '0;
                        r_hold  <= '0;
                    end
                end
                OWN: begin
                    // A release coinciding with the hold limit counts as voluntary,
                    // so preempt simply follows whether the owner still requests.
                    if (!req[r_owner] || (r_hold == HOLD_W'(MAX_HOLD))) begin
                        r_state   <= TURN;
                        r_gnt     <= '0;
                        r_owner   <= '0;
                        r_hold    <= '0;
                        r_preempt <= req[r_owner];
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_owner <= '0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign drv_en   = r_gnt;
    assign owner_id = r_owner;
    assign bus_busy = |r_gnt;
    assign preempt  = r_preempt;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter: default instance plus a MAX_HOLD=1 instance.
module tb_shared_bus_arbiter;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] drv_en;
    logic [1:0] owner_id;
    logic       bus_busy;
    logic       preempt;

    logic [3:0] req1;
    logic [3:0] gnt1;
    logic [3:0] drv_en1;
    logic [1:0] owner_id1;
    logic       bus_busy1;
    logic       preempt1;

    int n_cmp;
    int n_bad;

    tri1 w_bus;
    assign w_bus = (|drv_en) ? 1'b0 : 1'bz;

    shared_bus_arbiter #(
        .NREQ     (4),
        .MAX_HOLD (8)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .gnt      (gnt),
        .drv_en   (drv_en),
        .owner_id (owner_id),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    shared_bus_arbiter #(
        .NREQ     (4),
        .MAX_HOLD (1)
    ) dut1 (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req1),
        .gnt      (gnt1),
        .drv_en   (drv_en1),
        .owner_id (owner_id1),
        .bus_busy (bus_busy1),
        .preempt  (preempt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle invariants, sampled on the falling edge.
    always @(negedge clk) begin
        n_cmp++;
        assert ($onehot0(gnt) && $onehot0(gnt1)) else begin
            n_bad++;
            $display("FAIL onehot: gnt=%b gnt1=%b want at most one bit", gnt, gnt1);
        end
        n_cmp++;
        if (drv_en !== gnt || drv_en1 !== gnt1) begin
            n_bad++;
            $display("FAIL drv_eq_gnt: drv_en=%b gnt=%b drv_en1=%b gnt1=%b", drv_en, gnt, drv_en1, gnt1);
        end
        n_cmp++;
        if (bus_busy !== (gnt != 4'b0000)) begin
            n_bad++;
            $display("FAIL busy: bus_busy=%b gnt=%b", bus_busy, gnt);
        end
        n_cmp++;
        if ($isunknown(w_bus) || w_bus !== (gnt == 4'b0000)) begin
            n_bad++;
            $display("FAIL bus_level: bus=%b gnt=%b want %b", w_bus, gnt, (gnt == 4'b0000));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = 4'b0000;
        req1 = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req  = 4'b1111;
        req1 = 4'b1111;
        tick(2);
        n_cmp++;
        if (gnt !== 4'b0000 || drv_en !== 4'b0000 || owner_id !== 2'd0 || bus_busy !== 1'b0 || preempt !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: gnt=%b drv=%b owner=%0d busy=%b pre=%b want 0000 0000 0 0 0",
                     gnt, drv_en, owner_id, bus_busy, preempt);
        end
        do_reset();
        tick(1);
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_idle: gnt=%b want 0000", gnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0101;
        tick(1);
        n_cmp++;
        if (gnt !== 4'b0001 || owner_id !== 2'd0) begin
            n_bad++;
            $display("FAIL basic_first: gnt=%b owner=%0d want 0001 0", gnt, owner_id);
        end
        req = 4'b0100;
        tick(1);
        n_cmp++;
        if (gnt !== 4'b0000 || preempt !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_turn: gnt=%b pre=%b want 0000 0", gnt, preempt);
        end
        tick(1);
        n_cmp++;
        if (gnt !== 4'b0100 || owner_id !== 2'd2) begin
            n_bad++;
            $display("FAIL basic_second: gnt=%b owner=%0d want 0100 2", gnt, owner_id);
        end
        req = 4'b0000;
        tick(2);
        n_cmp++;
        if (gnt !== 4'b0000 || owner_id !== 2'd0) begin
            n_bad++;
            $display("FAIL basic_idle: gnt=%b owner=%0d want 0000 0", gnt, owner_id);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        int         ord [5];
        ord = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << ord[g];
            for (int c = 0; c < 8; c++) begin
                tick(1);
                n_cmp++;
                if (gnt !== exp_g || owner_id !== 2'(ord[g]) || preempt !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rot_drive g%0d c%0d: gnt=%b owner=%0d pre=%b want %b %0d 0",
                             g, c, gnt, owner_id, preempt, exp_g, ord[g]);
                end
            end
            tick(1);
            n_cmp++;
            if (gnt !== 4'b0000 || preempt !== 1'b1) begin
                n_bad++;
                $display("FAIL rot_turn g%0d: gnt=%b pre=%b want 0000 1", g, gnt, preempt);
            end
        end
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            n_cmp++;
            if (gnt !== 4'b0100) begin
                n_bad++;
                $display("FAIL single_drive c%0d: gnt=%b want 0100", c, gnt);
            end
        end
        tick(1);
        n_cmp++;
        if (gnt !== 4'b0000 || preempt !== 1'b1) begin
            n_bad++;
            $display("FAIL single_turn: gnt=%b pre=%b want 0000 1", gnt, preempt);
        end
        tick(1);
        n_cmp++;
        if (gnt !== 4'b0100 || owner_id !== 2'd2 || preempt !== 1'b0) begin
            n_bad++;
            $display("FAIL single_regrant: gnt=%b owner=%0d pre=%b want 0100 2 0", gnt, owner_id, preempt);
        end
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_release_at_max();
        do_reset();
        req = 4'b0010;
        tick(8);
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL relmax_hold8: gnt=%b want 0010", gnt);
        end
        req = 4'b0000;
        tick(1);
        n_cmp++;
        if (gnt !== 4'b0000 || preempt !== 1'b0) begin
            n_bad++;
            $display("FAIL relmax_turn: gnt=%b pre=%b want 0000 0", gnt, preempt);
        end
        tick(1);
        n_cmp++;
        if (gnt !== 4'b0000 || preempt !== 1'b0) begin
            n_bad++;
            $display("FAIL relmax_idle: gnt=%b pre=%b want 0000 0", gnt, preempt);
        end
    endtask

    task automatic test_nonowner();
        logic [3:0] pats [3];
        pats = '{4'b1111, 4'b0011, 4'b1001};
        do_reset();
        req = 4'b0001;
        tick(1);
        for (int p = 0; p < 3; p++) begin
            req = pats[p];
            tick(1);
            n_cmp++;
            if (gnt !== 4'b0001) begin
                n_bad++;
                $display("FAIL nonowner p%0d: gnt=%b want 0001", p, gnt);
            end
        end
        req = 4'b1010;
        tick(2);
        n_cmp++;
        if (gnt !== 4'b0010 || owner_id !== 2'd1) begin
            n_bad++;
            $display("FAIL nonowner_next: gnt=%b owner=%0d want 0010 1", gnt, owner_id);
        end
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_reset_mid_own();
        do_reset();
        req = 4'b0001;
        tick(3);
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || drv_en !== 4'b0000 || bus_busy !== 1'b0 || owner_id !== 2'd0) begin
            n_bad++;
            $display("FAIL async_reset: gnt=%b drv=%b busy=%b owner=%0d want 0000 0000 0 0",
                     gnt, drv_en, bus_busy, owner_id);
        end
        req = 4'b1000;
        #1;
        rstn = 1'b1;
        tick(1);
        n_cmp++;
        if (gnt !== 4'b1000 || owner_id !== 2'd3) begin
            n_bad++;
            $display("FAIL post_reset_grant: gnt=%b owner=%0d want 1000 3", gnt, owner_id);
        end
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_max_hold_one();
        logic [3:0] exp_g [5];
        logic       exp_p [5];
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
        exp_p = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        req1 = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            n_cmp++;
            if (gnt1 !== exp_g[c] || preempt1 !== exp_p[c]) begin
                n_bad++;
                $display("FAIL hold1 c%0d: gnt=%b pre=%b want %b %b", c, gnt1, preempt1, exp_g[c], exp_p[c]);
            end
        end
        req1 = 4'b0000;
        tick(2);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        req   = 4'b0000;
        req1  = 4'b0000;
        test_reset();
        test_basic();
        test_rotation();
        test_single();
        test_release_at_max();
        test_nonowner();
        test_reset_mid_own();
        test_max_hold_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
